div_share_ctrl: RTL and testbench
=================================

// Module: div_share_ctrl
// PURPOSE
//   Shares one iterative W-bit divider datapath among N_REQ requesters.
//   Round-robin arbitration; trivial cases (den==0, num<den) screened without using the divider.
//   Hangs detected by a timeout; one response pulse per accepted request.
//   Sits between client FSMs and the divider instance.
// PARAMETERS
//   N_REQ    4   number of requesters
//   W        4   operand/result width
//   TIMEOUT  20  cycles to wait for div_done before reporting timeout
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        reset, synchronous, active-high
//   req_valid  in   N_REQ    request pending per slot; held until accepted
//   req_num    in   N_REQ*W  numerators, slot i at [i*W +: W]
//   req_den    in   N_REQ*W  denominators, same packing
//   req_ready  out  N_REQ    one-hot accept; transfer = req_valid[i] & req_ready[i]
//   rsp_valid  out  N_REQ    one-hot, 1-cycle response pulse to the granted slot
//   rsp_quot   out  W        quotient, held until next response
//   rsp_rem    out  W        remainder, held until next response
//   rsp_err    out  2        00 ok, 01 div-by-zero, 10 timeout; held with data
//   div_load   out  1        1-cycle start pulse to divider
//   div_num    out  W        operand to divider; stable from div_load until done/timeout
//   div_den    out  W        operand to divider; stable from div_load until done/timeout
//   div_done   in   1        divider result valid
//   div_quot   in   W        divider quotient
//   div_rem    in   W        divider remainder
//   busy       out  1        high in every state except IDLE
// BEHAVIOUR
// - Reset: state IDLE, rr pointer 0, timeout counter 0. All outputs 0 (req_ready, rsp_*, div_*, busy).
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE:
//   - req_ready is combinational: one-hot of the first valid slot at or after the pointer (wrapping).
//   - On transfer: latch slot index g and operands; pointer <= (g+1) mod N_REQ.
//   - den==0: next RESP; quot = all ones, rem = num, err 01.
//   - num<den (den!=0): next RESP; quot 0, rem num, err 00.
//   - else: next ISSUE.
// - ISSUE: div_load=1 for exactly one cycle; clear counter; -> WAIT.
// - WAIT: counter increments each cycle.
//   - div_done: capture div_quot/div_rem, err 00 -> RESP.
//   - counter==TIMEOUT-1 without done: quot 0, rem 0, err 10 -> RESP.
//   - done and timeout in the same cycle: done wins.
// - RESP: rsp_valid[g]=1 for one cycle -> IDLE; no grant in this cycle.
// - Latency: accept at T.
//   - Screened cases: rsp at T+1.
//   - Divider path: div_load at T+1, rsp one cycle after the div_done cycle.
// - div_done outside WAIT is ignored.
// - req_valid deasserted by an ungranted slot: no effect.
// - Reset mid-operation: in-flight request dropped, no response. Client still holding valid is re-arbitrated.
// - Arithmetic: unsigned; no result width exceeds W.
// STRUCTURE
// - Shared package div_pkg: state enum, rsp_err codes (ERR_OK/ERR_DIV0/ERR_TMO), default W.
// - Sub-module div_rr_pick: combinational round-robin picker (valid vector + pointer -> one-hot grant, index, any).
// TESTING
// - Slot1 num=13 den=4, divider model done after 5 cycles -> div_load once; rsp_valid=0010, quot=3 rem=1 err=00.
// - Slot0 num=7 den=0 -> no div_load; rsp at T+1: quot=15 rem=7 err=01.
// - Slot2 num=3 den=9 -> no div_load; rsp at T+1: quot=0 rem=3 err=00.
// - All 4 slots valid continuously with pointer 0 -> grant order 0,1,2,3,0; no slot served twice before others.
// - Divider never asserts done -> rsp TIMEOUT+1 cycles after div_load with err=10 quot=0 rem=0.
// - Reset asserted during WAIT -> next cycle busy=0 and all outputs 0, no rsp_valid, pointer 0; request re-served after reset.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divider-sharing controller: FSM states, response error codes, default width.
package div_pkg;
  localparam int DIV_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} div_state_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
endpackage

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first valid slot at or after ptr, wrapping.
module div_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW-1:0] j;

  // Scan from farthest to nearest so the slot closest to ptr is written last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider among N_REQ requesters; screens den==0 / num<den locally,
// bounds each divider run with a timeout, and returns one response pulse per accepted request.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = DIV_W,
  parameter int TIMEOUT = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_num,
  input  logic [N_REQ*W-1:0] req_den,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_quot,
  output logic [W-1:0]       rsp_rem,
  output logic [1:0]         rsp_err,
  output logic               div_load,
  output logic [W-1:0]       div_num,
  output logic [W-1:0]       div_den,
  input  logic               div_done,
  input  logic [W-1:0]       div_quot,
  input  logic [W-1:0]       div_rem,
  output logic               busy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  div_state_e state, state_nx;

  logic [IW-1:0]    ptr, g, pick_idx, ptr_nx;
  logic [N_REQ-1:0] pick_grant;
  logic             pick_any, xfer, screened, tmo;
  logic [W-1:0]     num_a [N_REQ];
  logic [W-1:0]     den_a [N_REQ];
  logic [W-1:0]     sel_num, sel_den, op_num, op_den;
  logic [CW-1:0]    cnt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      num_a[i] = req_num[i*W +: W];
      den_a[i] = req_den[i*W +: W];
    end
  end

  div_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_num  = num_a[pick_idx];
  assign sel_den  = den_a[pick_idx];
  assign screened = (sel_den == '0) || (sel_num < sel_den);
  assign xfer     = (state == S_IDLE) && pick_any && !reset;
  assign ptr_nx   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign tmo      = (cnt == CW'(TIMEOUT - 1));

  assign req_ready = xfer ? pick_grant : '0;
  assign div_load  = (state == S_ISSUE);
  assign div_num   = op_num;
  assign div_den   = op_den;
  assign busy      = (state != S_IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (xfer) state_nx = screened ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (div_done || tmo) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result registers are loaded on the way into RESP so they are valid with the pulse and held after.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      g        <= '0;
      op_num   <= '0;
      op_den   <= '0;
      cnt      <= '0;
      rsp_quot <= '0;
      rsp_rem  <= '0;
      rsp_err  <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: if (xfer) begin
          g      <= pick_idx;
          op_num <= sel_num;
          op_den <= sel_den;
          ptr    <= ptr_nx;
          if (sel_den == '0) begin
            rsp_quot <= '1;
            rsp_rem  <= sel_num;
            rsp_err  <= ERR_DIV0;
          end else if (sel_num < sel_den) begin
            rsp_quot <= '0;
            rsp_rem  <= sel_num;
            rsp_err  <= ERR_OK;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            rsp_quot <= div_quot;
            rsp_rem  <= div_rem;
            rsp_err  <= ERR_OK;
          end else if (tmo) begin
            rsp_quot <= '0;
            rsp_rem  <= '0;
            rsp_err  <= ERR_TMO;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomized bench for div_share_ctrl: transaction-level reference model plus a behavioural divider.
module tb_div_share_ctrl;
  localparam int N = 4;
  localparam int W = 4;
  localparam int TMO = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_num = '0;
  logic [N*W-1:0] req_den = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_quot, rsp_rem, div_num, div_den;
  logic [1:0]     rsp_err;
  logic           div_load, busy;
  logic           div_done = 1'b0;
  logic [W-1:0]   div_quot = '0, div_rem = '0;

  div_share_ctrl #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .div_load(div_load), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  bit rst_q = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Stimulus / divider controls
  bit auto_drv = 0, refill = 0, hang = 0, spur = 0, rand_dly = 0;
  int dly = 3;

  // Reference model state
  bit         mbusy = 0;
  int         ptr_m = 0, g_m = 0, op_n = 0, op_d = 0;
  int         e_q = 0, e_r = 0, e_e = 0;
  int         load_due = -1, rsp_due = -1, acc_cyc = 0;
  int         n_rsp = 0, act_loads = 0, last_load_cyc = 0, last_rsp_cyc = 0;
  int         last_rsp_vec = 0;
  logic [N-1:0] xfer_mask = '0;
  int         grant_log[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_q = reset;
  end

  // Reference model: checks every output once per cycle on the falling edge.
  initial forever begin
    bit b;
    int exp_r, gi;
    @(negedge clk);
    if (rst_q) begin
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_div_load", div_load, 0);
      chk("rst_rsp_data", {rsp_quot, rsp_rem, rsp_err}, 0);
      chk("rst_div_ops", {div_num, div_den}, 0);
      mbusy = 0; ptr_m = 0; load_due = -1; rsp_due = -1;
    end
    xfer_mask = '0;
    if (div_load) act_loads++;
    b = mbusy;
    chk("busy", busy, b);
    if (b && load_due >= 0) begin
      chk("div_load", div_load, cyc == load_due);
      if (cyc == load_due) begin
        last_load_cyc = cyc;
        chk("div_num", div_num, op_n);
        chk("div_den", div_den, op_d);
      end else if (cyc > load_due && rsp_due < 0) begin
        chk("div_ops_stable", {div_num, div_den}, (op_n << W) | op_d);
        if (div_done) begin
          rsp_due = cyc + 1; e_q = op_n / op_d; e_r = op_n % op_d; e_e = 0;
        end else if (cyc == load_due + TMO) begin
          rsp_due = cyc + 1; e_q = 0; e_r = 0; e_e = 2;
        end
      end
    end else begin
      chk("div_load", div_load, 0);
    end
    chk("rsp_valid", rsp_valid, (b && cyc == rsp_due) ? (1 << g_m) : 0);
    if (b && cyc == rsp_due) begin
      chk("rsp_quot", rsp_quot, e_q);
      chk("rsp_rem", rsp_rem, e_r);
      chk("rsp_err", rsp_err, e_e);
      n_rsp++; last_rsp_cyc = cyc; last_rsp_vec = rsp_valid; mbusy = 0;
    end else if (b && cyc - acc_cyc > TMO + 10) begin
      chk("rsp_overdue", cyc - acc_cyc, TMO + 10);
      mbusy = 0;
    end
    exp_r = 0; gi = 0;
    if (!b && !reset) begin
      for (int k = 0; k < N; k++) begin
        if (exp_r == 0 && req_valid[(ptr_m + k) % N]) begin
          gi = (ptr_m + k) % N;
          exp_r = 1 << gi;
        end
      end
    end
    chk("req_ready", req_ready, exp_r);
    if (exp_r != 0) begin
      g_m = gi; acc_cyc = cyc; mbusy = 1; ptr_m = (gi + 1) % N;
      op_n = int'((req_num >> (gi * W)) & 16'hF);
      op_d = int'((req_den >> (gi * W)) & 16'hF);
      xfer_mask = N'(exp_r);
      grant_log.push_back(gi);
      if (op_d == 0) begin
        rsp_due = cyc + 1; load_due = -1; e_q = 15; e_r = op_n; e_e = 1;
      end else if (op_n < op_d) begin
        rsp_due = cyc + 1; load_due = -1; e_q = 0; e_r = op_n; e_e = 0;
      end else begin
        load_due = cyc + 1; rsp_due = -1;
      end
    end
  end

  // Behavioural divider: result after a chosen number of cycles, or never; optional stray done pulses.
  initial begin
    bit pending = 0, th = 0;
    int rem_c = 0, ln = 0, ld = 1;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (reset) begin
        pending = 0;
      end else begin
        if (pending && rsp_valid != 0) pending = 0;
        if (div_load) begin
          pending = 1; ln = div_num; ld = div_den; th = hang; rem_c = dly;
          if (rand_dly) begin
            case ($urandom_range(0, 9))
              0: th = 1;
              1: rem_c = TMO;
              default: rem_c = $urandom_range(1, 8);
            endcase
          end
        end else if (pending) begin
          if (!th) begin
            rem_c--;
            if (rem_c == 0) begin
              div_done = 1'b1; div_quot = W'(ln / ld); div_rem = W'(ln % ld);
            end
          end
        end else if (spur && $urandom_range(0, 7) == 0) begin
          div_done = 1'b1; div_quot = W'($urandom); div_rem = W'($urandom);
        end
      end
    end
  end

  // Clients: drop valid once accepted; in auto mode raise random requests and occasionally withdraw.
  initial forever begin
    @(posedge clk); #2;
    if (!refill) req_valid &= ~xfer_mask;
    if (auto_drv) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req_num[i*W +: W] = W'($urandom_range(0, 15));
            req_den[i*W +: W] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(0, 15));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int s, input int nm, input int dn);
    @(posedge clk); #3;
    req_num[s*W +: W] = W'(nm);
    req_den[s*W +: W] = W'(dn);
    req_valid[s] = 1'b1;
  endtask

  task automatic wait_rsp(input int n0);
    for (int t = 0; t < 300 && n_rsp == n0; t++) @(posedge clk);
    chk("rsp_arrived", n_rsp - n0, 1);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && mbusy; t++) @(posedge clk);
    chk("drain", mbusy, 0);
  endtask

  initial begin
    int n0, a0, s;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // Divider path 13/4
    dly = 5; n0 = n_rsp; a0 = act_loads;
    set_req(1, 13, 4);
    wait_rsp(n0);
    chk("t1_quot", rsp_quot, 3); chk("t1_rem", rsp_rem, 1); chk("t1_err", rsp_err, 0);
    chk("t1_loads", act_loads - a0, 1); chk("t1_vec", last_rsp_vec, 4'b0010);
    chk("t1_latency", last_rsp_cyc - last_load_cyc, 6);

    // Divide by zero
    n0 = n_rsp; a0 = act_loads;
    set_req(0, 7, 0);
    wait_rsp(n0);
    chk("t2_quot", rsp_quot, 15); chk("t2_rem", rsp_rem, 7); chk("t2_err", rsp_err, 1);
    chk("t2_loads", act_loads - a0, 0); chk("t2_latency", last_rsp_cyc - acc_cyc, 1);

    // num < den
    n0 = n_rsp; a0 = act_loads;
    set_req(2, 3, 9);
    wait_rsp(n0);
    chk("t3_quot", rsp_quot, 0); chk("t3_rem", rsp_rem, 3); chk("t3_err", rsp_err, 0);
    chk("t3_loads", act_loads - a0, 0); chk("t3_latency", last_rsp_cyc - acc_cyc, 1);

    // All slots valid continuously from pointer 0
    pulse_reset();
    s = grant_log.size();
    refill = 1;
    @(posedge clk); #3;
    for (int i = 0; i < N; i++) begin
      req_num[i*W +: W] = W'(i + 1);
      req_den[i*W +: W] = '0;
    end
    req_valid = '1;
    for (int t = 0; t < 100 && grant_log.size() < s + 5; t++) @(posedge clk);
    chk("t4_count", grant_log.size() >= s + 5, 1);
    for (int k = 0; k < 5; k++)
      if (s + k < grant_log.size()) chk("t4_grant", grant_log[s + k], k % N);
    #3 refill = 0; req_valid = '0;
    wait_idle();

    // Divider never answers
    hang = 1; n0 = n_rsp;
    set_req(3, 9, 2);
    wait_rsp(n0);
    chk("t5_err", rsp_err, 2); chk("t5_quot", rsp_quot, 0); chk("t5_rem", rsp_rem, 0);
    chk("t5_latency", last_rsp_cyc - last_load_cyc, TMO + 1);

    // Reset during WAIT, then the client retries
    n0 = n_rsp; a0 = act_loads;
    set_req(1, 14, 3);
    for (int t = 0; t < 50 && act_loads == a0; t++) @(posedge clk);
    chk("t6_loaded", act_loads - a0, 1);
    repeat (3) @(posedge clk);
    pulse_reset();
    @(posedge clk); #1;
    chk("t6_no_rsp", n_rsp, n0);
    hang = 0; dly = 3;
    set_req(1, 14, 3);
    wait_rsp(n0);
    chk("t6_quot", rsp_quot, 4); chk("t6_rem", rsp_rem, 2); chk("t6_err", rsp_err, 0);

    // Random traffic with random divider latency, hangs and stray done pulses
    spur = 1; rand_dly = 1; auto_drv = 1;
    repeat (3000) @(posedge clk);
    #3 auto_drv = 0; req_valid = '0;
    wait_idle();
    spur = 0; rand_dly = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
